// File: rtl/wordle_game_ctrl.sv
// Wordle round controller: assembles keyboard guesses, scores them green/yellow/gray with
// duplicate-aware matching, and tracks guess count and win/lose for one round.
module wordle_game_ctrl #(
  parameter int unsigned WORD_LEN    = 5,
  parameter int unsigned MAX_GUESSES = 6,
  parameter int unsigned GL_W        = $clog2(WORD_LEN + 1),
  parameter int unsigned GN_W        = $clog2(MAX_GUESSES + 1)
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*WORD_LEN-1:0] secret_word,
  input  logic                  letter_valid,
  input  logic [7:0]            letter_in,
  input  logic                  backspace,
  input  logic                  enter,
  output logic [8*WORD_LEN-1:0] guess_word,
  output logic [GL_W-1:0]       guess_len,
  output logic [GN_W-1:0]       guess_num,
  output logic [2*WORD_LEN-1:0] score,
  output logic                  score_valid,
  output logic                  busy,
  output logic                  win,
  output logic                  lose
);

  localparam int unsigned IW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StScoreG,
    StScoreY,
    StResult,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          secret_q [WORD_LEN];
  logic [7:0]          secret_d [WORD_LEN];
  logic [7:0]          guess_q  [WORD_LEN];
  logic [7:0]          guess_d  [WORD_LEN];
  logic [1:0]          work_q   [WORD_LEN];
  logic [1:0]          work_d   [WORD_LEN];
  logic [1:0]          score_q  [WORD_LEN];
  logic [1:0]          score_d  [WORD_LEN];
  logic [GL_W-1:0]     len_q, len_d;
  logic [GN_W-1:0]     num_q, num_d;
  logic [WORD_LEN-1:0] green_q, green_d;
  logic [WORD_LEN-1:0] used_q, used_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                win_q, win_d;
  logic                lose_q, lose_d;

  logic [7:0]          letter_up;
  logic                is_letter;
  logic [7:0]          cur_guess;
  logic                cur_green;
  logic [WORD_LEN-1:0] found_oh;
  logic                found;

  always_comb begin
    letter_up = letter_in;
    if (letter_in >= 8'h61 && letter_in <= 8'h7a) begin
      letter_up = letter_in - 8'h20;
    end
    is_letter = (letter_up >= 8'h41) && (letter_up <= 8'h5a);
  end

  // Lowest unused secret position matching the guess letter under scrutiny.
  always_comb begin
    cur_guess = 8'h00;
    cur_green = 1'b0;
    for (int unsigned p = 0; p < WORD_LEN; p++) begin
      if (IW'(p) == idx_q) begin
        cur_guess = guess_q[p];
        cur_green = green_q[p];
      end
    end
    found    = 1'b0;
    found_oh = '0;
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      if (!found && !used_q[j] && (secret_q[j] == cur_guess)) begin
        found       = 1'b1;
        found_oh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    work_d   = work_q;
    score_d  = score_q;
    len_d    = len_q;
    num_d    = num_q;
    green_d  = green_q;
    used_d   = used_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    win_d    = win_q;
    lose_d   = lose_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          for (int unsigned p = 0; p < WORD_LEN; p++) begin
            secret_d[p] = secret_word[8*(WORD_LEN-1-p) +: 8];
            guess_d[p]  = 8'h00;
            score_d[p]  = 2'b00;
          end
          num_d   = GN_W'(1);
          len_d   = '0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          state_d = StEntry;
        end
      end
      StEntry: begin
        // A pending enter blocks the other strobes even when it is not accepted.
        if (enter) begin
          if (len_q == GL_W'(WORD_LEN)) begin
            state_d = StScoreG;
          end
        end else if (backspace) begin
          if (len_q != '0) begin
            len_d = len_q - GL_W'(1);
            for (int unsigned p = 0; p < WORD_LEN; p++) begin
              if (GL_W'(p) == len_d) begin
                guess_d[p] = 8'h00;
              end
            end
          end
        end else if (letter_valid) begin
          if (is_letter && (len_q < GL_W'(WORD_LEN))) begin
            for (int unsigned p = 0; p < WORD_LEN; p++) begin
              if (GL_W'(p) == len_q) begin
                guess_d[p] = letter_up;
              end
            end
            len_d = len_q + GL_W'(1);
          end
        end
      end
      StScoreG: begin
        for (int unsigned p = 0; p < WORD_LEN; p++) begin
          green_d[p] = (guess_q[p] == secret_q[p]);
          work_d[p]  = green_d[p] ? 2'b11 : 2'b01;
        end
        used_d  = green_d;
        idx_d   = '0;
        state_d = StScoreY;
      end
      StScoreY: begin
        if (!cur_green && found) begin
          for (int unsigned p = 0; p < WORD_LEN; p++) begin
            if (IW'(p) == idx_q) begin
              work_d[p] = 2'b10;
            end
          end
          used_d = used_q | found_oh;
        end
        if (idx_q == IW'(WORD_LEN - 1)) begin
          state_d = StResult;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StResult: begin
        score_d = work_q;
        valid_d = 1'b1;
        if (&green_q) begin
          win_d   = 1'b1;
          state_d = StDone;
        end else if (num_q == GN_W'(MAX_GUESSES)) begin
          lose_d  = 1'b1;
          state_d = StDone;
        end else begin
          num_d = num_q + GN_W'(1);
          len_d = '0;
          for (int unsigned p = 0; p < WORD_LEN; p++) begin
            guess_d[p] = 8'h00;
          end
          state_d = StEntry;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      for (int unsigned p = 0; p < WORD_LEN; p++) begin
        secret_q[p] <= 8'h00;
        guess_q[p]  <= 8'h00;
        work_q[p]   <= 2'b00;
        score_q[p]  <= 2'b00;
      end
      len_q   <= '0;
      num_q   <= '0;
      green_q <= '0;
      used_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      work_q   <= work_d;
      score_q  <= score_d;
      len_q    <= len_d;
      num_q    <= num_d;
      green_q  <= green_d;
      used_q   <= used_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
    end
  end

  always_comb begin
    guess_word = '0;
    score      = '0;
    for (int unsigned p = 0; p < WORD_LEN; p++) begin
      guess_word[8*(WORD_LEN-1-p) +: 8] = guess_q[p];
      score[2*(WORD_LEN-1-p) +: 2]      = score_q[p];
    end
  end

  assign guess_len   = len_q;
  assign guess_num   = num_q;
  assign score_valid = valid_q;
  assign busy        = (state_q == StScoreG) || (state_q == StScoreY);
  assign win         = win_q;
  assign lose        = lose_q;

endmodule
